// File: rtl/instr_fifo.sv
// Decoded micro-instruction buffer between the decoder and dispatch.
// One push per cycle in, the two oldest entries out, 0..2 retired per cycle, single-cycle flush.
`ifndef DECODE_INFO_DW
`define DECODE_INFO_DW 32
`endif

module instr_fifo #(
   parameter  int DW    = `DECODE_INFO_DW,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          flush,
   input  logic          instrFifo_push,
   input  logic [DW-1:0] decode_microInstr,
   output logic          instrFifo_reject,
   output logic          dispatch_valid0,
   output logic [DW-1:0] dispatch_info0,
   output logic          dispatch_valid1,
   output logic [DW-1:0] dispatch_info1,
   input  logic [1:0]    dispatch_pop,
   output logic [AW:0]   fifo_count,
   output logic          fifo_empty
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   rd_ptr;
   logic [AW:0]   wr_ptr;
   logic [AW:0]   count;
   logic [AW-1:0] rd_idx0;
   logic [AW-1:0] rd_idx1;
   logic [AW-1:0] wr_idx;
   logic [1:0]    pop_req;
   logic [AW:0]   pop_eff;
   logic          push_acc;

   // Full/empty are told apart by the wrap bit, so the subtraction is exact modulo 2^(AW+1).
   assign count   = wr_ptr - rd_ptr;
   assign rd_idx0 = rd_ptr[AW-1:0];
   assign rd_idx1 = rd_ptr[AW-1:0] + AW'(1);
   assign wr_idx  = wr_ptr[AW-1:0];

   // Reject is taken from registered state only; a same-cycle pop never frees a slot for the push.
   assign instrFifo_reject = (count == (AW+1)'(DEPTH));
   assign push_acc         = instrFifo_push & ~instrFifo_reject & ~flush;

   always_comb begin
      pop_req = (dispatch_pop == 2'd3) ? 2'd2 : dispatch_pop;
      pop_eff = ((AW+1)'(pop_req) > count) ? count : (AW+1)'(pop_req);
   end

   assign dispatch_valid0 = (count != '0);
   assign dispatch_valid1 = (count > (AW+1)'(1));
   assign dispatch_info0  = mem[rd_idx0];
   assign dispatch_info1  = mem[rd_idx1];
   assign fifo_count      = count;
   assign fifo_empty      = (count == '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[AW'(i)] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         rd_ptr <= rd_ptr + pop_eff;
         if (push_acc) begin
            mem[wr_idx] <= decode_microInstr;
            wr_ptr      <= wr_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_instr_fifo.sv
// Randomized and directed bench for instr_fifo against a queue-based occupancy model.
`timescale 1ns/1ps

module tb_instr_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          CLK = 1'b0;
   logic          RST;
   logic          flush;
   logic          instrFifo_push;
   logic [DW-1:0] decode_microInstr;
   logic          instrFifo_reject;
   logic          dispatch_valid0;
   logic [DW-1:0] dispatch_info0;
   logic          dispatch_valid1;
   logic [DW-1:0] dispatch_info1;
   logic [1:0]    dispatch_pop;
   logic [AW:0]   fifo_count;
   logic          fifo_empty;

   instr_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .CLK(CLK),
      .RST(RST),
      .flush(flush),
      .instrFifo_push(instrFifo_push),
      .decode_microInstr(decode_microInstr),
      .instrFifo_reject(instrFifo_reject),
      .dispatch_valid0(dispatch_valid0),
      .dispatch_info0(dispatch_info0),
      .dispatch_valid1(dispatch_valid1),
      .dispatch_info1(dispatch_info1),
      .dispatch_pop(dispatch_pop),
      .fifo_count(fifo_count),
      .fifo_empty(fifo_empty)
   );

   always #5 CLK = ~CLK;

   // Dispatch must never request three entries.
   assert property (@(posedge CLK) dispatch_pop != 2'd3);

   logic [DW-1:0] q[$];
   int            n_total = 0;
   int            n_pass  = 0;
   bit            checking = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Apply one cycle of inputs, advance the model with the same inputs across the edge.
   task automatic step(input bit rst, input bit fl, input bit push, input logic [DW-1:0] data,
                       input int pop);
      int pe;
      RST               = rst;
      flush             = fl;
      instrFifo_push    = push;
      decode_microInstr = data;
      dispatch_pop      = 2'(pop);
      @(posedge CLK);
      if (rst || fl) begin
         q.delete();
      end else begin
         bit acc;
         acc = push && (q.size() < DEPTH);
         pe  = (pop < q.size()) ? pop : q.size();
         repeat (pe) void'(q.pop_front());
         if (acc) q.push_back(data);
      end
      #1;
   endtask

   always @(negedge CLK) begin
      if (checking) begin
         chk("count",  64'(fifo_count), 64'(q.size()));
         chk("empty",  64'(fifo_empty), 64'(q.size() == 0));
         chk("reject", 64'(instrFifo_reject), 64'(q.size() == DEPTH));
         chk("valid0", 64'(dispatch_valid0), 64'(q.size() >= 1));
         chk("valid1", 64'(dispatch_valid1), 64'(q.size() >= 2));
         if (q.size() >= 1) chk("info0", 64'(dispatch_info0), 64'(q[0]));
         if (q.size() >= 2) chk("info1", 64'(dispatch_info1), 64'(q[1]));
      end
   end

   initial begin
      RST = 1'b1; flush = 1'b0; instrFifo_push = 1'b0; decode_microInstr = '0; dispatch_pop = 2'd0;

      // Reset held two cycles with push asserted.
      step(1, 0, 1, 32'hDEAD, 0);
      step(1, 0, 1, 32'hBEEF, 0);
      checking = 1'b1;
      @(negedge CLK);
      chk("rst_count",  64'(fifo_count), 64'd0);
      chk("rst_empty",  64'(fifo_empty), 64'd1);
      chk("rst_reject", 64'(instrFifo_reject), 64'd0);
      chk("rst_valid0", 64'(dispatch_valid0), 64'd0);
      chk("rst_valid1", 64'(dispatch_valid1), 64'd0);
      chk("rst_info0",  64'(dispatch_info0), 64'd0);
      chk("rst_info1",  64'(dispatch_info1), 64'd0);

      // Fill to full.
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 1, DW'(i), 0);
         if (i == 1) chk("first_vis", 64'(dispatch_info0), 64'h1);
      end
      chk("full_count",  64'(fifo_count), 64'd8);
      chk("full_reject", 64'(instrFifo_reject), 64'd1);
      chk("full_info0",  64'(dispatch_info0), 64'h1);
      chk("full_info1",  64'(dispatch_info1), 64'h2);
      step(0, 0, 1, 32'h9, 0);
      chk("held_count", 64'(fifo_count), 64'd8);
      chk("held_info0", 64'(dispatch_info0), 64'h1);

      // Full with pop: push still rejected, then accepted next cycle.
      step(0, 0, 1, 32'h9, 2);
      chk("fpop_count", 64'(fifo_count), 64'd6);
      chk("fpop_info0", 64'(dispatch_info0), 64'h3);
      step(0, 0, 1, 32'h9, 0);
      chk("fpop2_count",  64'(fifo_count), 64'd7);
      chk("fpop2_reject", 64'(instrFifo_reject), 64'd0);
      chk("fpop2_info1",  64'(dispatch_info1), 64'h4);

      // Dual pop across the index wrap.
      for (int i = 0; i < 10; i++) step(0, 0, 1, DW'(32'h10 + i), (i % 2 == 0) ? 2 : 0);
      while (q.size() > 0) step(0, 0, 0, '0, 2);

      // Over-pop clamp.
      step(0, 0, 1, 32'h55, 0);
      chk("op_count1", 64'(fifo_count), 64'd1);
      step(0, 0, 0, '0, 2);
      chk("op_count0", 64'(fifo_count), 64'd0);
      step(0, 0, 1, 32'hA, 0);
      chk("op_info0",  64'(dispatch_info0), 64'hA);
      chk("op_valid1", 64'(dispatch_valid1), 64'd0);
      step(0, 0, 0, '0, 1);

      // Flush mid-stream with push and pop in the same cycle.
      for (int i = 0; i < 5; i++) step(0, 0, 1, DW'(32'h21 + i), 0);
      chk("fl_pre_count", 64'(fifo_count), 64'd5);
      step(0, 1, 1, 32'h99, 1);
      chk("fl_count",  64'(fifo_count), 64'd0);
      chk("fl_empty",  64'(fifo_empty), 64'd1);
      chk("fl_reject", 64'(instrFifo_reject), 64'd0);
      chk("fl_valid0", 64'(dispatch_valid0), 64'd0);
      step(0, 0, 1, 32'h77, 0);
      chk("fl_next_info0", 64'(dispatch_info0), 64'h77);
      chk("fl_next_count", 64'(fifo_count), 64'd1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit r, f, p;
         int pop;
         r   = ($urandom_range(499) == 0);
         f   = ($urandom_range(39) == 0);
         p   = ($urandom_range(99) < 60);
         pop = $urandom_range(2);
         step(r, f, p, $urandom, pop);
      end

      checking = 1'b0;
      @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
